lock_key_sequencer: RTL

- Controller in front of the locked 8-bit adder datapath (input vector in, 1-bit locked output back).
- Loads the secret key serially, MSB first, into a held key register. Presents that register on the datapath's key port.
- Sequences operand requests through the datapath using valid/ready and returns each locked result bit on a response handshake.
- Sits between the test/key-provisioning interface and the locked design top.

---
 rtl/lock_key_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lock_key_sequencer.sv
// rtl/lock_key_sequencer.sv - serial key loader and request sequencer for the locked adder datapath
// Optional build macro: KEY_LOAD_LIMIT_EN (caps completed key loads per reset at MAX_LOADS).
module lock_key_sequencer #(
    parameter int IN_W      = 8,
    parameter int KEY_W     = 8,
    parameter int MAX_LOADS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_start,
    input  logic              key_bit,
    input  logic              key_bit_valid,
    output logic              key_loaded,
    output logic [KEY_W-1:0]  key,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IN_W-1:0]   req_data,
    output logic [IN_W-1:0]   inputs,
    input  logic              lock_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               key_loaded_q, key_loaded_d;
    logic [IN_W-1:0]    inputs_q, inputs_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               load_done;
    logic               start_ok;

`ifdef KEY_LOAD_LIMIT_EN
    localparam int LCNT_W = $clog2(MAX_LOADS + 1);

    logic [LCNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic               limit_hit;

    assign limit_hit = (load_cnt_q == LCNT_W'(MAX_LOADS));
    // Once the budget is spent the key is frozen until the next reset.
    assign start_ok  = key_start && !limit_hit;

    always_comb begin
        load_cnt_d = load_cnt_q;
        if (load_done && !limit_hit) begin
            load_cnt_d = load_cnt_q + LCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q <= '0;
        end else begin
            load_cnt_q <= load_cnt_d;
        end
    end
`else
    logic unused_max_loads;

    assign unused_max_loads = ^MAX_LOADS;
    assign start_ok         = key_start;
`endif

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        key_loaded_d = key_loaded_q;
        inputs_d     = inputs_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        bit_cnt_d    = bit_cnt_q;
        req_ready    = 1'b0;
        load_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d      = S_LOAD;
                    bit_cnt_d    = '0;
                    key_loaded_d = 1'b0;
                end
            end
            S_LOAD: begin
                // A restart wins over a bit presented in the same cycle.
                if (key_start) begin
                    bit_cnt_d = '0;
                end else if (key_bit_valid) begin
                    key_d     = {key_q[KEY_W-2:0], key_bit};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(KEY_W - 1)) begin
                        state_d      = S_ARMED;
                        key_loaded_d = 1'b1;
                        load_done    = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (start_ok) begin
                    state_d      = S_LOAD;
                    bit_cnt_d    = '0;
                    key_loaded_d = 1'b0;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        inputs_d = req_data;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rsp_data_d  = lock_out;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_ARMED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            key_loaded_q <= 1'b0;
            inputs_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 1'b0;
            bit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            key_loaded_q <= key_loaded_d;
            inputs_q     <= inputs_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    assign key        = key_q;
    assign key_loaded = key_loaded_q;
    assign inputs     = inputs_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_ARMED);

endmodule
